// File: rtl/exec_stage.sv
// exec_stage: registered Y86-64 execute stage.
// Wraps the ADD/SUB/AND/XOR ALU behind a valid/ready handshake with a
// one-entry output register, keeps the ZF/SF/OF condition codes and
// evaluates the branch/cmov condition against the codes left by the
// previous instruction.
// Optional build macro EXEC_STAGE_STATS_EN adds op_count and
// cc_write_count counter outputs.
module exec_stage #(
    parameter int W     = 64,
    parameter int DST_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alufun,
    input  logic [3:0]       cond,
    input  logic             set_cc,
    input  logic [W-1:0]     valA,
    input  logic [W-1:0]     valB,
    input  logic [DST_W-1:0] dst_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     valE,
    output logic             cnd,
    output logic [DST_W-1:0] dst_out,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             err
`ifdef EXEC_STAGE_STATS_EN
    ,
    output logic [31:0]      op_count,
    output logic [31:0]      cc_write_count
`endif
);

    // Signed overflow of an addition: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != b_msb);
    endfunction

    // Signed overflow of B - A: operands differ in sign, result differs from B.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != b_msb);
    endfunction

    logic             out_valid_q;
    logic [W-1:0]     val_e_q;
    logic             cnd_q;
    logic [DST_W-1:0] dst_q;
    logic             err_q;
    logic             zf_q;
    logic             sf_q;
    logic             of_q;

    logic [W-1:0]     val_e_d;
    logic             ovf_d;
    logic             fun_ok_s;
    logic             cnd_d;
    logic             cond_ok_s;
    logic             accept_s;
    logic             cc_load_s;

    // in_ready depends only on the output register state and downstream ready.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign cc_load_s = accept_s && set_cc && fun_ok_s;

    // ALU result and overflow for the operation on the inputs.
    always_comb begin
        val_e_d  = {W{1'b0}};
        ovf_d    = 1'b0;
        fun_ok_s = 1'b1;
        case (alufun)
            4'd0: begin
                val_e_d = valB + valA;
                ovf_d   = add_ovf(valA[W-1], valB[W-1], val_e_d[W-1]);
            end
            4'd1: begin
                val_e_d = valB - valA;
                ovf_d   = sub_ovf(valA[W-1], valB[W-1], val_e_d[W-1]);
            end
            4'd2: val_e_d = valB & valA;
            4'd3: val_e_d = valB ^ valA;
            default: begin
                val_e_d  = {W{1'b0}};
                fun_ok_s = 1'b0;
            end
        endcase
    end

    // Condition evaluated against the codes held before this op updates them.
    always_comb begin
        cnd_d     = 1'b0;
        cond_ok_s = 1'b1;
        case (cond)
            4'd0: cnd_d = 1'b1;
            4'd1: cnd_d = (sf_q ^ of_q) | zf_q;
            4'd2: cnd_d = sf_q ^ of_q;
            4'd3: cnd_d = zf_q;
            4'd4: cnd_d = !zf_q;
            4'd5: cnd_d = !(sf_q ^ of_q);
            4'd6: cnd_d = !(sf_q ^ of_q) && !zf_q;
            default: begin
                cnd_d     = 1'b0;
                cond_ok_s = 1'b0;
            end
        endcase
    end

    // Output register and condition-code register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            val_e_q     <= {W{1'b0}};
            cnd_q       <= 1'b0;
            dst_q       <= {DST_W{1'b0}};
            err_q       <= 1'b0;
            zf_q        <= 1'b1;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            if (accept_s) begin
                out_valid_q <= 1'b1;
                val_e_q     <= val_e_d;
                cnd_q       <= cnd_d;
                dst_q       <= dst_in;
                err_q       <= !fun_ok_s || !cond_ok_s;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
            if (cc_load_s) begin
                zf_q <= (val_e_d == {W{1'b0}});
                sf_q <= val_e_d[W-1];
                of_q <= ovf_d;
            end else begin
                zf_q <= zf_q;
                sf_q <= sf_q;
                of_q <= of_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign valE      = val_e_q;
    assign cnd       = cnd_q;
    assign dst_out   = dst_q;
    assign err       = err_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = of_q;

`ifdef EXEC_STAGE_STATS_EN
    logic [31:0] op_count_q;
    logic [31:0] cc_write_count_q;

    // Accepted-operation and CC-load counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q       <= 32'd0;
            cc_write_count_q <= 32'd0;
        end else begin
            if (accept_s) begin
                op_count_q <= op_count_q + 32'd1;
            end else begin
                op_count_q <= op_count_q;
            end
            if (cc_load_s) begin
                cc_write_count_q <= cc_write_count_q + 32'd1;
            end else begin
                cc_write_count_q <= cc_write_count_q;
            end
        end
    end

    assign op_count       = op_count_q;
    assign cc_write_count = cc_write_count_q;
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage.
module tb_exec_stage;
    localparam int W = 64;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alufun;
    logic [3:0]    cond;
    logic          set_cc;
    logic [W-1:0]  valA;
    logic [W-1:0]  valB;
    logic [3:0]    dst_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  valE;
    logic          cnd;
    logic [3:0]    dst_out;
    logic          zf;
    logic          sf;
    logic          of;
    logic          err;
`ifdef EXEC_STAGE_STATS_EN
    logic [31:0]   op_count;
    logic [31:0]   cc_write_count;
`endif

    int total = 0;
    int bad   = 0;

    exec_stage #(.W(W), .DST_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alufun(alufun), .cond(cond), .set_cc(set_cc), .valA(valA), .valB(valB),
        .dst_in(dst_in), .out_valid(out_valid), .out_ready(out_ready),
        .valE(valE), .cnd(cnd), .dst_out(dst_out), .zf(zf), .sf(sf), .of(of),
        .err(err)
`ifdef EXEC_STAGE_STATS_EN
        , .op_count(op_count), .cc_write_count(cc_write_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation on the inputs (no checking here).
    task automatic drive(input logic [3:0] f, input logic [3:0] c, input logic sc,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] d);
        in_valid = 1'b1;
        alufun   = f;
        cond     = c;
        set_cc   = sc;
        valA     = a;
        valB     = b;
        dst_in   = d;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alufun = 4'd0; cond = 4'd0; set_cc = 1'b0;
        valA = 64'd0; valB = 64'd0; dst_in = 4'd0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (valE !== 64'd0) begin bad++; $display("FAIL reset_valE got=%h exp=0", valE); end
        total++; if ({zf, sf, of} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b exp=100", {zf, sf, of}); end
        total++; if ({cnd, err, dst_out} !== 6'd0) begin bad++; $display("FAIL reset_misc got=%b exp=0", {cnd, err, dst_out}); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_xor();
        drive(4'd3, 4'd0, 1'b1, 64'd19, 64'd23, 4'd1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL xor_pre_valid got=%b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || valE !== 64'd4) begin bad++; $display("FAIL xor1 got v=%b %0d exp v=1 4", out_valid, valE); end
        total++; if (zf !== 1'b0 || dst_out !== 4'd1) begin bad++; $display("FAIL xor1_zf_dst got zf=%b dst=%0d exp 0 1", zf, dst_out); end
        drive(4'd3, 4'd0, 1'b1, 64'd25, 64'd72, 4'd2);
        step();
        total++; if (valE !== 64'd81) begin bad++; $display("FAIL xor2 got=%0d exp=81", valE); end
        drive(4'd3, 4'd0, 1'b1, -64'sd12, -64'sd13, 4'd3);
        step();
        total++; if (valE !== 64'd7 || {zf, sf, of} !== 3'b000) begin bad++; $display("FAIL xor3 got=%0d f=%b exp=7 f=000", valE, {zf, sf, of}); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || valE !== 64'd7) begin bad++; $display("FAIL xor_drain got v=%b %0d exp v=0 7", out_valid, valE); end
    endtask

    task automatic test_add_ovf();
        drive(4'd0, 4'd0, 1'b1, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'd4);
        step();
        total++; if (valE !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL add_ovf_val got=%h exp=8000000000000000", valE); end
        total++; if ({zf, sf, of} !== 3'b011) begin bad++; $display("FAIL add_ovf_flags got=%b exp=011", {zf, sf, of}); end
        drive(4'd2, 4'd2, 1'b0, 64'd0, 64'd0, 4'd5);
        step();
        total++; if (cnd !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL add_then_l got cnd=%b err=%b exp 0 0", cnd, err); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_sub_cond();
        drive(4'd1, 4'd0, 1'b1, 64'd5, 64'd5, 4'd6);
        step();
        total++; if (valE !== 64'd0 || {zf, sf, of} !== 3'b100) begin bad++; $display("FAIL sub_eq got=%0d f=%b exp=0 f=100", valE, {zf, sf, of}); end
        drive(4'd0, 4'd3, 1'b0, 64'd1, 64'd2, 4'd7);
        step();
        total++; if (cnd !== 1'b1 || valE !== 64'd3) begin bad++; $display("FAIL cond_e got cnd=%b val=%0d exp 1 3", cnd, valE); end
        total++; if (zf !== 1'b1) begin bad++; $display("FAIL no_setcc_zf got=%b exp=1", zf); end
        drive(4'd0, 4'd6, 1'b0, 64'd0, 64'd0, 4'd7);
        step();
        total++; if (cnd !== 1'b0) begin bad++; $display("FAIL cond_g_zf got=%b exp=0", cnd); end
        // 0 - 1 = -1: SF=1, OF=0, so l and le hold, ge fails.
        drive(4'd1, 4'd0, 1'b1, 64'd1, 64'd0, 4'd8);
        step();
        total++; if (valE !== 64'hFFFF_FFFF_FFFF_FFFF || {zf, sf, of} !== 3'b010) begin bad++; $display("FAIL sub_neg got=%h f=%b exp=ffffffffffffffff f=010", valE, {zf, sf, of}); end
        drive(4'd2, 4'd2, 1'b0, 64'd0, 64'd0, 4'd9);
        step();
        total++; if (cnd !== 1'b1) begin bad++; $display("FAIL cond_l got=%b exp=1", cnd); end
        drive(4'd2, 4'd5, 1'b0, 64'd0, 64'd0, 4'd9);
        step();
        total++; if (cnd !== 1'b0) begin bad++; $display("FAIL cond_ge got=%b exp=0", cnd); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 64'd10, 64'd20, 4'd1);
        step();
        out_ready = 1'b0;
        drive(4'd3, 4'd0, 1'b0, 64'hF0, 64'h0F, 4'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_ready cyc=%0d got rdy=%b v=%b exp 0 1", i, in_ready, out_valid); end
            total++; if (valE !== 64'd30 || dst_out !== 4'd1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%0d dst=%0d exp=30 1", i, valE, dst_out); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        step();
        total++; if (out_valid !== 1'b1 || valE !== 64'hFF || dst_out !== 4'd2) begin bad++; $display("FAIL bp_replace got v=%b %h dst=%0d exp 1 ff 2", out_valid, valE, dst_out); end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || valE !== 64'hFF) begin bad++; $display("FAIL bp_no_dup got v=%b %h exp 0 ff", out_valid, valE); end
    endtask

    task automatic test_illegal();
        drive(4'd1, 4'd0, 1'b1, 64'd5, 64'd5, 4'd1);
        step();
        drive(4'd9, 4'd0, 1'b1, 64'd1, 64'd2, 4'd3);
        step();
        total++; if (valE !== 64'd0 || err !== 1'b1 || cnd !== 1'b1) begin bad++; $display("FAIL bad_fun got=%0d err=%b cnd=%b exp=0 1 1", valE, err, cnd); end
        total++; if ({zf, sf, of} !== 3'b100) begin bad++; $display("FAIL bad_fun_cc got=%b exp=100", {zf, sf, of}); end
        drive(4'd0, 4'd12, 1'b0, 64'd1, 64'd1, 4'd4);
        step();
        total++; if (cnd !== 1'b0 || err !== 1'b1 || valE !== 64'd2) begin bad++; $display("FAIL bad_cond got cnd=%b err=%b val=%0d exp 0 1 2", cnd, err, valE); end
        drive(4'd0, 4'd0, 1'b0, 64'd1, 64'd1, 4'd4);
        step();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_inflight();
        drive(4'd1, 4'd0, 1'b1, 64'd1, 64'd0, 4'd5);
        step();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1 || sf !== 1'b1) begin bad++; $display("FAIL pre_rst got v=%b sf=%b exp 1 1", out_valid, sf); end
        rst = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || {zf, sf, of} !== 3'b100) begin bad++; $display("FAIL rst_inflight got v=%b f=%b exp 0 100", out_valid, {zf, sf, of}); end
`ifdef EXEC_STAGE_STATS_EN
        total++; if (op_count !== 32'd0 || cc_write_count !== 32'd0) begin bad++; $display("FAIL rst_counts got=%0d %0d exp 0 0", op_count, cc_write_count); end
`endif
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_xor();
        test_add_ovf();
        test_sub_cond();
        test_back_to_back();
        test_illegal();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Registered execute stage for the 64-bit Y86-64 datapath; sits directly downstream of the decode/operand-fetch logic and wraps the combinational ALU ops (ADD, SUB, AND, XOR).
- Accepts one operation per cycle through a valid/ready handshake and holds the result in a one-entry output register.
- Maintains the condition-code register (ZF, SF, OF) and evaluates the branch/cmov condition Cnd for the memory/writeback stage.

Parameters:
- W, 64, datapath width in bits.
- DST_W, 4, width of the destination-register tag carried alongside the result.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an operation.
- in_ready  output  1  stage can accept; equals (!out_valid || out_ready).
- alufun  input  4  0=ADD, 1=SUB, 2=AND, 3=XOR; other codes are illegal.
- cond  input  4  Y86 condition code for Cnd: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
- set_cc  input  1  update ZF/SF/OF from this operation.
- valA  input  W  operand A.
- valB  input  W  operand B.
- dst_in  input  DST_W  destination tag, passed through unchanged.
- out_valid  output  1  result register holds a valid entry.
- out_ready  input  1  downstream consumes this cycle.
- valE  output  W  registered ALU result.
- cnd  output  1  registered condition result.
- dst_out  output  DST_W  registered destination tag.
- zf, sf, of  output  1 each  current condition-code register.
- err  output  1  registered flag: illegal alufun or illegal cond on this entry.

Behaviour:
- Reset (rst high at an edge):
  - out_valid=0, valE=0, cnd=0, dst_out=0, err=0.
  - zf=1, sf=0, of=0.
  - Reset overrides any simultaneous accept; an in-flight entry is discarded.
- Accept: occurs when in_valid && in_ready at a rising edge. Latency is 1 cycle: the result is visible with out_valid=1 after that edge.
- Arithmetic (modulo 2^W):
  - ADD: valE = valB + valA.
  - SUB: valE = valB - valA.
  - AND: valE = valB & valA.
  - XOR: valE = valB ^ valA.
  - Illegal alufun: valE=0, err=1.
- Flags, computed on the W-bit result:
  - ZF = (valE==0).
  - SF = valE[W-1].
  - ADD OF = (A[W-1]==B[W-1]) && (valE[W-1]!=B[W-1]).
  - SUB OF = (A[W-1]!=B[W-1]) && (valE[W-1]!=B[W-1]).
  - AND/XOR OF = 0.
- CC register:
  - Loads at the accepting edge only when set_cc=1 and alufun is legal.
  - Otherwise it holds, including when no accept occurs.
- Cnd: evaluated from the CC value before this operation's own update (prior-instruction semantics).
  - le = (SF^OF)|ZF
  - l = SF^OF
  - e = ZF
  - ne = !ZF
  - ge = !(SF^OF)
  - g = !(SF^OF) && !ZF
  - cond 7..15: cnd=0, err=1.
- Output register:
  - Holds its entry (valE, cnd, dst_out, err all stable) while out_valid && !out_ready.
  - If out_valid && out_ready and in_valid in the same cycle, the new entry replaces the old one at that edge (full throughput, no bubble).
  - If out_ready && !in_valid, out_valid drops to 0. The data fields hold their last value.
- in_ready is combinational from out_valid and out_ready only. It never depends on in_valid.
- No combinational path from valA/valB to any output.

Optional Feature:
- Macro: EXEC_STAGE_STATS_EN.
- When defined:
  - Adds output op_count [31:0], which increments by 1 on each accepting edge and wraps 0xFFFFFFFF -> 0.
  - Adds output cc_write_count [31:0], which increments on each CC load.
  - Both counters reset to 0.
- When undefined: neither port nor the counters exist. The rest of the behaviour is identical.

Test Plan:
- XOR vectors, each with out_ready=1 and set_cc=1:
  - A=19, B=23 -> valE=4, zf=0.
  - A=25, B=72 -> valE=81.
  - A=-12, B=-13 -> valE=7, sf=0, of=0.
  - Each result appears exactly 1 cycle after accept.
- ADD A=1, B=0x7FFF_FFFF_FFFF_FFFF, set_cc=1 -> valE=0x8000_0000_0000_0000, sf=1, of=1, zf=0.
  - Next op: cond=2 (l) -> cnd=0, because SF^OF=0 from the prior CC.
- SUB A=5, B=5, set_cc=1 -> valE=0, zf=1.
  - Next op: cond=3 -> cnd=1.
  - A following op with set_cc=0 leaves zf=1.
- Backpressure: hold out_ready=0 with in_valid=1 for 3 cycles.
  - in_ready=0 and the first result stays stable.
  - Then raise out_ready with a new op present -> the entry is replaced in one cycle with no dropped or duplicated op.
- alufun=9 -> valE=0, err=1, CC unchanged.
  - Separately, cond=12 -> cnd=0, err=1.
- Assert rst while out_valid=1 and in_valid=1 -> the next cycle shows out_valid=0, zf=1, sf=0, of=0.
  - With EXEC_STAGE_STATS_EN defined, op_count=0.
